pipe_skid_ctrl: RTL and testbench
=================================

PIPE_SKID_CTRL -- requirements
Module: pipe_skid_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 177, the payload width in bits of one pipeline word.
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall counter width in bits.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 Port in_valid  input  1  upstream word present on in_data.
REQ-006 Port in_ready  output  1  stage accepts a word this cycle.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port out_valid  output  1  word present on out_data.
REQ-009 Port out_ready  input  1  downstream consumes the word this cycle.
REQ-010 Port out_data  output  WIDTH  head payload.
REQ-011 Port flush  input  1  synchronous discard of all held words.
REQ-012 Port occupancy  output  2  number of words held: 0, 1 or 2.
REQ-013 Port stall_cnt  output  CNT_W  downstream stall cycle count; present only per REQ-032.

Function
REQ-014 The block SHALL hold two WIDTH-bit enable-loaded registers, main (head) and skid (second), under a 3-state FSM: EMPTY (0 words), BUSY (main valid), FULL (main and skid valid).
REQ-015 The block SHALL define accept = in_valid & in_ready and consume = out_valid & out_ready.
REQ-016 In EMPTY, accept SHALL load main with in_data and go to BUSY; otherwise stay EMPTY.
REQ-017 In BUSY, accept & consume SHALL load main with in_data and stay BUSY; accept alone SHALL load skid and go to FULL; consume alone SHALL go to EMPTY; neither SHALL hold.
REQ-018 In FULL, consume SHALL copy skid into main and go to BUSY; otherwise hold.
REQ-019 in_ready SHALL be 1 in EMPTY and BUSY, 0 in FULL, decoded from registered state only (no combinational path from out_ready to in_ready).
REQ-020 out_valid SHALL be 1 in BUSY and FULL; out_data SHALL equal main at all times.
REQ-021 occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-022 Latency SHALL be one cycle: a word accepted at edge N appears on out_data after edge N when the stage was EMPTY.
REQ-023 Sustained throughput SHALL be one word per cycle while out_ready is held 1.
REQ-024 Words SHALL leave in acceptance order; none SHALL be dropped or duplicated outside flush.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-026 flush=1 at an edge SHALL force EMPTY at that edge, overriding any simultaneous accept or consume; the word on in_data that cycle is discarded; data register contents are don't-care.
REQ-027 A register SHALL load only on its defined load condition; no register SHALL toggle otherwise (power).

Reset
REQ-028 Asserting reset low SHALL asynchronously force EMPTY, main=0, skid=0, stall_cnt=0.
REQ-029 During and immediately after reset: in_ready=1, out_valid=0, out_data=0, occupancy=0.
REQ-030 Reset asserted mid-operation SHALL discard all held words; the first word after deassertion follows REQ-016.
REQ-031 Deassertion SHALL take effect at the first rising clk edge with reset high.

Configuration
REQ-032 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL exist and increment by 1 on every edge where out_valid=1 and out_ready=0, saturating at 2^CNT_W-1, unaffected by flush, cleared only by reset.
REQ-033 Without PIPE_STALL_CNT_EN, port stall_cnt and its counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-034 Reset low, then high; in_valid=1 in_data=0x5 for one cycle, out_ready=1 -> out_valid=1 out_data=0x5 next cycle, then out_valid=0.
REQ-035 out_ready=0; push 0xA, 0xB -> occupancy=2, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB out, occupancy 2->1->0.
REQ-036 Stream 0x1..0x64, out_ready=1 throughout -> 100 words out in order, one per cycle, in_ready never 0.
REQ-037 FULL with in_valid=1 and flush=1 same cycle -> next cycle occupancy=0, out_valid=0; pushed word never appears.
REQ-038 With PIPE_STALL_CNT_EN, CNT_W=4, hold out_valid=1 out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); assert reset low mid-stall -> stall_cnt=0, out_valid=0 immediately.

Source files
------------

// File: rtl/pipe_skid_ctrl_if.sv
// Valid/ready handshake bundle for the two-entry skid stage.
// master drives upstream data, downstream ready and flush; slave is the stage.
interface pipe_skid_ctrl_if #(
  parameter int WIDTH = 177
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Two-entry skid pipeline stage (main + skid) with registered in_ready.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_skid_ctrl #(
  parameter int WIDTH = 177,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_skid_ctrl_if.slave  bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main;
  logic             load_skid;
  logic             from_skid;
  logic             accept;
  logic             consume;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        unique case (1'b1)
          accept & consume: load_main = 1'b1;
          accept & ~consume: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          ~accept & consume: state_d = EMPTY;
          default: state_d = BUSY;
        endcase
      end
      FULL: begin
        if (consume) begin
          load_main = 1'b1;
          from_skid = 1'b1;
          state_d   = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush wins; held data becomes don't-care so skip the loads
    if (bus.flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         main_q <= '0;
    else if (load_main) main_q <= from_skid ? skid_q : bus.in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         skid_q <= '0;
    else if (load_skid) skid_q <= bus.in_data;
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_skid_ctrl.sv
// Directed bench for pipe_skid_ctrl with a queue scoreboard on output order.
// Build with PIPE_STALL_CNT_EN to also exercise the stall counter.
module tb_pipe_skid_ctrl;
  localparam int W = 177;
  localparam int C = 4;

  logic clk;
  logic reset;
`ifdef PIPE_STALL_CNT_EN
  logic [C-1:0] stall_cnt;
`endif

  pipe_skid_ctrl_if #(.WIDTH(W)) bus ();

  pipe_skid_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int base;
  logic [W-1:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept/consume are judged mid-cycle, ahead of the edge that acts on them
  always @(negedge clk) begin
    if (!reset || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) chk("out_order", bus.out_data, sb.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    step();
    step();
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data", bus.out_data, W'(0));
    chk("rst_occ", W'(bus.occupancy), W'(0));
    reset = 1'b1;
    step();
    chk("post_rst_occ", W'(bus.occupancy), W'(0));

    // single word, one-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(5);
    step();
    bus.in_valid = 1'b0;
    chk("lat_valid", W'(bus.out_valid), W'(1));
    chk("lat_data", bus.out_data, W'(5));
    step();
    chk("lat_drain", W'(bus.out_valid), W'(0));

    // fill to FULL under backpressure, then drain
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(10);
    step();
    bus.in_data = W'(11);
    step();
    bus.in_valid = 1'b0;
    chk("full_occ", W'(bus.occupancy), W'(2));
    chk("full_in_ready", W'(bus.in_ready), W'(0));
    chk("full_head", bus.out_data, W'(10));
    repeat (3) step();
    chk("stall_stable", bus.out_data, W'(10));
    bus.out_ready = 1'b1;
    step();
    chk("drain1_occ", W'(bus.occupancy), W'(1));
    chk("drain1_data", bus.out_data, W'(11));
    step();
    chk("drain2_occ", W'(bus.occupancy), W'(0));
    chk("drain2_valid", W'(bus.out_valid), W'(0));

    // full-rate stream
    base = n_out;
    for (int i = 1; i <= 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(i);
      chk("stream_in_ready", W'(bus.in_ready), W'(1));
      step();
      chk("stream_occ", W'(bus.occupancy), W'(1));
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_count", W'(n_out - base), W'(100));
    chk("stream_empty", W'(bus.occupancy), W'(0));

    // flush while FULL with a word offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(8'h11);
    step();
    bus.in_data = W'(8'h22);
    step();
    chk("pre_flush_occ", W'(bus.occupancy), W'(2));
    bus.in_data = W'(16'hDEAD);
    bus.flush   = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_occ", W'(bus.occupancy), W'(0));
    chk("flush_valid", W'(bus.out_valid), W'(0));
    chk("flush_in_ready", W'(bus.in_ready), W'(1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(8'h33);
    step();
    bus.in_valid = 1'b0;
    chk("post_flush_data", bus.out_data, W'(8'h33));
    step();
    chk("post_flush_empty", W'(bus.occupancy), W'(0));

    // asynchronous reset mid-operation
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(8'h44);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_occ", W'(bus.occupancy), W'(1));
    reset = 1'b0;
    #1;
    chk("async_rst_occ", W'(bus.occupancy), W'(0));
    chk("async_rst_valid", W'(bus.out_valid), W'(0));
    chk("async_rst_data", bus.out_data, W'(0));
    step();
    step();
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(8'h55);
    step();
    bus.in_valid = 1'b0;
    chk("after_rst_data", bus.out_data, W'(8'h55));
    chk("after_rst_occ", W'(bus.occupancy), W'(1));
    step();
    chk("after_rst_empty", W'(bus.occupancy), W'(0));

`ifdef PIPE_STALL_CNT_EN
    reset = 1'b0;
    #1;
    reset = 1'b1;
    chk("stall_cnt_rst", W'(stall_cnt), W'(0));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(8'h66);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    chk("stall_cnt_5", W'(stall_cnt), W'(5));
    repeat (15) step();
    chk("stall_cnt_sat", W'(stall_cnt), W'(15));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("stall_cnt_flush", W'(stall_cnt), W'(15));
    reset = 1'b0;
    #1;
    chk("stall_cnt_async", W'(stall_cnt), W'(0));
    chk("stall_rst_valid", W'(bus.out_valid), W'(0));
    step();
    reset = 1'b1;
    step();
`endif

    chk("sb_drained", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
